// File: rtl/read_data_steering.sv
// Read-data router and wait-state sequencer for the internal XT data bus.
// Optional access timeout is enabled by defining BUS_TIMEOUT_EN.
module read_data_steering #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned NUM_SOURCES    = 4,
  parameter int unsigned WAIT_WIDTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  localparam int unsigned SrcW          = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              memory_read_n,
  input  logic                              io_read_n,
  input  logic [NUM_SOURCES-1:0]            source_select_n,
  input  logic [NUM_SOURCES*DATA_WIDTH-1:0] source_data,
  input  logic [NUM_SOURCES-1:0]            source_ready,
  input  logic [NUM_SOURCES*WAIT_WIDTH-1:0] source_wait_states,
  input  logic [DATA_WIDTH-1:0]             data_bus_ext,
  input  logic                              external_direction,
  output logic [DATA_WIDTH-1:0]             data_bus_out,
  output logic                              data_bus_direction,
  output logic                              read_ready,
  output logic [SrcW-1:0]                   active_source,
  output logic                              active_valid,
  output logic                              bus_timeout
);

  typedef enum logic [2:0] {StIdle, StExt, StWait, StAccess, StHold} state_e;

  state_e                state_q, state_d;
  logic [WAIT_WIDTH-1:0] wait_q, wait_d;
  logic [DATA_WIDTH-1:0] latch_q, latch_d;
  logic [SrcW-1:0]       src_q, src_d;
  logic                  valid_q, valid_d;

  logic                  read_active;
  logic                  hit;
  logic [SrcW-1:0]       idx;
  logic [WAIT_WIDTH-1:0] sel_wait;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_ready;

  assign read_active = ~memory_read_n | ~io_read_n;
  assign hit         = ~&source_select_n;

  // Scan high to low so the lowest asserted index is the final assignment.
  always_comb begin
    idx = '0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (!source_select_n[i]) idx = SrcW'(i);
    end
  end

  assign sel_wait  = source_wait_states[int'(idx) * WAIT_WIDTH +: WAIT_WIDTH];
  assign sel_data  = source_data[int'(src_q) * DATA_WIDTH +: DATA_WIDTH];
  assign sel_ready = source_ready[src_q];

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            tmo_pulse_q, tmo_pulse_d;
`endif

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    latch_d = latch_q;
    src_d   = src_q;
    valid_d = valid_q;
`ifdef BUS_TIMEOUT_EN
    tmo_d       = tmo_q;
    tmo_pulse_d = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (read_active && hit) begin
          src_d   = idx;
          valid_d = 1'b1;
          wait_d  = sel_wait;
          state_d = (sel_wait != '0) ? StWait : StAccess;
`ifdef BUS_TIMEOUT_EN
          tmo_d = '0;
`endif
        end else if (read_active) begin
          state_d = StExt;
        end
      end
      StExt: begin
        if (!read_active) state_d = StIdle;
      end
      StWait: begin
        if (!read_active) begin
          state_d = StIdle;
          valid_d = 1'b0;
        end else begin
          wait_d = wait_q - WAIT_WIDTH'(1);
          if (wait_q <= WAIT_WIDTH'(1)) begin
            state_d = StAccess;
`ifdef BUS_TIMEOUT_EN
            tmo_d = '0;
`endif
          end
        end
      end
      StAccess: begin
        if (!read_active) begin
          state_d = StIdle;
          valid_d = 1'b0;
        end else if (sel_ready) begin
          latch_d = sel_data;
          state_d = StHold;
`ifdef BUS_TIMEOUT_EN
        end else if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
          latch_d     = '1;
          tmo_pulse_d = 1'b1;
          state_d     = StHold;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
`endif
        end
      end
      StHold: begin
        if (!read_active) begin
          state_d = StIdle;
          valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      wait_q      <= '0;
      latch_q     <= '0;
      src_q       <= '0;
      valid_q     <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      tmo_q       <= '0;
      tmo_pulse_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      latch_q     <= latch_d;
      src_q       <= src_d;
      valid_q     <= valid_d;
`ifdef BUS_TIMEOUT_EN
      tmo_q       <= tmo_d;
      tmo_pulse_q <= tmo_pulse_d;
`endif
    end
  end

  always_comb begin
    data_bus_out       = '0;
    data_bus_direction = 1'b0;
    read_ready         = 1'b1;
    unique case (state_q)
      StIdle: begin
        data_bus_out       = external_direction ? data_bus_ext : '0;
        data_bus_direction = external_direction;
        read_ready         = ~(read_active & hit);
      end
      StExt: begin
        data_bus_out       = external_direction ? data_bus_ext : '0;
        data_bus_direction = external_direction;
      end
      StWait, StAccess: read_ready = 1'b0;
      StHold:           data_bus_out = latch_q;
      default: ;
    endcase
  end

  assign active_source = src_q;
  assign active_valid  = valid_q;
`ifdef BUS_TIMEOUT_EN
  assign bus_timeout = tmo_pulse_q;
`else
  assign bus_timeout = 1'b0;
`endif

endmodule
